// File: rtl/cell_write_arbiter.sv
// Write-port arbiter for the character-cell buffer: two requesters with
// round-robin tie-break, commits only during vertical blanking, plus a
// full-buffer clear sequence that overrides both requesters.
module cell_write_arbiter #(
    parameter int unsigned CELL_HORIZONTAL_LENGHT = 52,
    parameter int unsigned CELL_VERTICAL_LENGHT   = 40,
    parameter int unsigned ADDR_W                 = 12,
    parameter int unsigned DATA_W                 = 8,
    parameter int unsigned CLEAR_VALUE            = 0
) (
    input  logic              CLK_IN,
    input  logic              RST,
    input  logic              i_vblank,
    input  logic              i_req0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_data0,
    output logic              o_ack0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_data1,
    output logic              o_ack1,
    input  logic              i_clear,
    output logic              o_clear_done,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata
);

    localparam int unsigned       CELLS     = CELL_HORIZONTAL_LENGHT * CELL_VERTICAL_LENGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [DATA_W-1:0] CLR_DATA  = DATA_W'(CLEAR_VALUE);

    // DONE is the single cycle in which the last clear write is visible on
    // o_we; it issues o_clear_done and drops the pending flag on exit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic              clr_pend, clr_pend_n;
    logic              rr_last, rr_last_n;     // 1: port 1 was granted last
    logic [ADDR_W-1:0] clr_addr, clr_addr_n;
    logic              we_n, ack0_n, ack1_n, err_n, done_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [DATA_W-1:0] wdata_n;

    logic elig0, elig1, gnt1, bad0, bad1;

    // A port acked this cycle sits out one cycle so a held request is not written twice.
    assign elig0 = i_req0 & ~o_ack0;
    assign elig1 = i_req1 & ~o_ack1;
    assign gnt1  = elig1 & (~elig0 | ~rr_last);
    assign bad0  = 32'(i_addr0) >= CELLS;
    assign bad1  = 32'(i_addr1) >= CELLS;
    assign o_busy = clr_pend;

    // Next-state, arbitration and clear sequencing.
    always_comb begin
        state_n    = state;
        clr_pend_n = clr_pend;
        rr_last_n  = rr_last;
        clr_addr_n = clr_addr;
        we_n       = 1'b0;
        waddr_n    = o_waddr;
        wdata_n    = o_wdata;
        ack0_n     = 1'b0;
        ack1_n     = 1'b0;
        err_n      = 1'b0;
        done_n     = 1'b0;

        if (i_clear && !clr_pend) begin
            clr_pend_n = 1'b1;
            clr_addr_n = '0;
        end

        case (state)
            IDLE: begin
                if (clr_pend) begin
                    if (i_vblank) state_n = CLEAR;
                end else if (i_vblank && (elig0 || elig1)) begin
                    if (gnt1) begin
                        ack1_n    = 1'b1;
                        rr_last_n = 1'b1;
                        if (bad1) begin
                            err_n = 1'b1;
                        end else begin
                            we_n    = 1'b1;
                            waddr_n = i_addr1;
                            wdata_n = i_data1;
                        end
                    end else begin
                        ack0_n    = 1'b1;
                        rr_last_n = 1'b0;
                        if (bad0) begin
                            err_n = 1'b1;
                        end else begin
                            we_n    = 1'b1;
                            waddr_n = i_addr0;
                            wdata_n = i_data0;
                        end
                    end
                end
            end
            CLEAR: begin
                if (!i_vblank) begin
                    state_n = PAUSE;
                end else begin
                    we_n    = 1'b1;
                    waddr_n = clr_addr;
                    wdata_n = CLR_DATA;
                    if (clr_addr == LAST_ADDR) state_n = DONE;
                    else clr_addr_n = clr_addr + ADDR_W'(1);
                end
            end
            PAUSE: begin
                if (i_vblank) state_n = CLEAR;
            end
            DONE: begin
                state_n    = IDLE;
                done_n     = 1'b1;
                clr_pend_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            clr_pend     <= 1'b0;
            rr_last      <= 1'b1;
            clr_addr     <= '0;
            o_we         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_ack0       <= 1'b0;
            o_ack1       <= 1'b0;
            o_err        <= 1'b0;
            o_clear_done <= 1'b0;
        end else begin
            state        <= state_n;
            clr_pend     <= clr_pend_n;
            rr_last      <= rr_last_n;
            clr_addr     <= clr_addr_n;
            o_we         <= we_n;
            o_waddr      <= waddr_n;
            o_wdata      <= wdata_n;
            o_ack0       <= ack0_n;
            o_ack1       <= ack1_n;
            o_err        <= err_n;
            o_clear_done <= done_n;
        end
    end

endmodule
